// File: rtl/alu_pkg.sv
// Definitions shared by the operand stage and the 8-bit ALU.
package alu_pkg;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 8;
  localparam int REG_AW   = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_ADD = 3'b001,
    ALU_XOR = 3'b010,
    ALU_SLT = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SNE = 3'b110,
    ALU_NOP = 3'b111
  } alu_op_t;
endpackage

// File: rtl/reg_file.sv
// Architectural register file: one write port, two combinational read ports
// with write-first bypass so a same-cycle write-back is visible to readers.
module reg_file #(
  parameter  int NUM_REGS = alu_pkg::NUM_REGS,
  parameter  int DATA_W   = alu_pkg::DATA_W,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    regs[r] <= '0;
      else if (we && (waddr == AW'(unsigned'(r))))   regs[r] <= wdata;
    end
  end

  assign rdata_a = (we && (waddr == raddr_a)) ? wdata : regs[raddr_a];
  assign rdata_b = (we && (waddr == raddr_b)) ? wdata : regs[raddr_b];
endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage: reads/bypasses operands and registers them for the ALU,
// keeping held operands coherent with write-back while stalled.
module alu_operand_stage #(
  parameter  int NUM_REGS = alu_pkg::NUM_REGS,
  parameter  int DATA_W   = alu_pkg::DATA_W,
  localparam int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opcode,
  input  logic [REG_AW-1:0] in_rs_a,
  input  logic [REG_AW-1:0] in_rs_b,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_input_a,
  output logic [DATA_W-1:0] alu_input_b,
  output logic [2:0]        alu_opcode,
  output logic [REG_AW-1:0] out_rd,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);
  logic [DATA_W-1:0] rd_a, rd_b, opb_nxt;
  logic [REG_AW-1:0] rs_a_q, rs_b_q;
  logic              use_imm_q;
  alu_pkg::alu_op_t  op_q;
  logic              accept;

  reg_file #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (in_rs_a),
    .rdata_a (rd_a),
    .raddr_b (in_rs_b),
    .rdata_b (rd_b)
  );

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready && !flush;
  assign opb_nxt    = in_use_imm ? in_imm : rd_b;
  assign alu_opcode = op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      alu_input_a <= '0;
      alu_input_b <= '0;
      op_q        <= alu_pkg::ALU_AND;
      out_rd      <= '0;
      rs_a_q      <= '0;
      rs_b_q      <= '0;
      use_imm_q   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      alu_input_a <= rd_a;
      alu_input_b <= opb_nxt;
      op_q        <= alu_pkg::alu_op_t'(in_opcode);
      out_rd      <= in_rd;
      rs_a_q      <= in_rs_a;
      rs_b_q      <= in_rs_b;
      use_imm_q   <= in_use_imm;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      // Stalled: track write-back into held sources so the ALU never sees stale data.
      if (wb_en && (wb_addr == rs_a_q))               alu_input_a <= wb_data;
      if (wb_en && !use_imm_q && (wb_addr == rs_b_q)) alu_input_b <= wb_data;
    end
  end
endmodule
